trap_sequencer: RTL and testbench

Machine-mode trap controller that arbitrates between synchronous exceptions, `mret` and pending interrupts, then sequences trap entry or exit through pipeline flush, CSR update and PC redirect. It sits between the commit/exception logic and the CSR unit. It consumes exception and interrupt codes from the shared RISC-V type definitions (`exception_code_t`, `interrupt_code_t`, `MCAUSE`/`MEPC`/`MTVAL`/`MTVEC` layout).

---
 rtl/trap_sequencer_if.sv | 44 ++++
 rtl/trap_sequencer.sv | 134 +++++++++++++
 tb/tb_trap_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// Signal bundle between trap_sequencer (slave) and the commit/CSR side (master).
// Handshake: *_valid is a level held by the requester until its one-cycle *_ack; interrupts are levels with no ack.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            exception_valid;
    logic [4:0]      exception_code;
    logic [XLEN-1:0] exception_pc;
    logic [XLEN-1:0] exception_tval;
    logic            exception_ack;
    logic            mret_valid;
    logic            mret_ack;
    logic [15:0]     mip;
    logic [15:0]     mie;
    logic            mstatus_mie;
    logic [XLEN-1:0] interrupt_pc;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc_in;
    logic            flush_req;
    logic            drain_ack;
    logic            csr_we;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mtval;
    logic            mret_commit;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;
    logic            busy;
    logic [1:0]      dbg_state;

    modport slave (
        input  exception_valid, exception_code, exception_pc, exception_tval,
        input  mret_valid, mip, mie, mstatus_mie, interrupt_pc, mtvec, mepc_in, drain_ack,
        output exception_ack, mret_ack, flush_req, csr_we, mcause, mepc, mtval,
        output mret_commit, redirect_valid, redirect_addr, busy, dbg_state
    );

    modport master (
        output exception_valid, exception_code, exception_pc, exception_tval,
        output mret_valid, mip, mie, mstatus_mie, interrupt_pc, mtvec, mepc_in, drain_ack,
        input  exception_ack, mret_ack, flush_req, csr_we, mcause, mepc, mtval,
        input  mret_commit, redirect_valid, redirect_addr, busy, dbg_state
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exception > mret > interrupt, then runs flush, CSR write, redirect.
// Optional macro TRAP_VECTORED_EN: mtvec MODE=01 sends interrupts to BASE + 4*code.
module trap_sequencer #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              rst,
    trap_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WRITE, S_REDIRECT} state_e;
    typedef enum logic [1:0] {K_EXC, K_MRET, K_IRQ} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;

    logic [15:0]     irq_pend;
    logic            irq_hit;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign irq_pend = bus.mip & bus.mie;

    // Fixed interrupt priority; bits outside this list never trap.
    always_comb begin
        irq_hit  = bus.mstatus_mie;
        irq_code = 5'd0;
        if (irq_pend[11])      irq_code = 5'd11;
        else if (irq_pend[3])  irq_code = 5'd3;
        else if (irq_pend[7])  irq_code = 5'd7;
        else if (irq_pend[9])  irq_code = 5'd9;
        else if (irq_pend[1])  irq_code = 5'd1;
        else if (irq_pend[5])  irq_code = 5'd5;
        else if (irq_pend[13]) irq_code = 5'd13;
        else                   irq_hit  = 1'b0;
    end

    assign trap_base = bus.mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
    assign trap_target = (kind_q == K_IRQ && bus.mtvec[1:0] == 2'b01)
                       ? trap_base + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        state_d            = state_q;
        kind_d             = kind_q;
        cause_d            = cause_q;
        epc_d              = epc_q;
        tval_d             = tval_q;
        bus.exception_ack  = 1'b0;
        bus.mret_ack       = 1'b0;
        bus.csr_we         = 1'b0;
        bus.mret_commit    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.mcause         = '0;
        bus.mepc           = '0;
        bus.mtval          = '0;
        bus.redirect_addr  = '0;
        case (state_q)
            S_IDLE: begin
                // Acks are suppressed during reset so a held request is accepted once reset releases.
                if (!rst) begin
                    if (bus.exception_valid) begin
                        bus.exception_ack = 1'b1;
                        kind_d  = K_EXC;
                        cause_d = {{(XLEN-5){1'b0}}, bus.exception_code};
                        epc_d   = bus.exception_pc & ~XLEN'(1);
                        tval_d  = bus.exception_tval;
                        state_d = S_FLUSH;
                    end else if (bus.mret_valid) begin
                        bus.mret_ack = 1'b1;
                        kind_d  = K_MRET;
                        state_d = S_FLUSH;
                    end else if (irq_hit) begin
                        kind_d  = K_IRQ;
                        cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                        tval_d  = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.drain_ack) begin
                    if (kind_q == K_IRQ) epc_d = bus.interrupt_pc;
                    state_d = (kind_q == K_MRET) ? S_REDIRECT : S_WRITE;
                end
            end
            S_WRITE: begin
                bus.csr_we = 1'b1;
                bus.mcause = cause_q;
                bus.mepc   = epc_q;
                bus.mtval  = tval_q;
                state_d    = S_REDIRECT;
            end
            S_REDIRECT: begin
                bus.redirect_valid = 1'b1;
                if (kind_q == K_MRET) begin
                    bus.mret_commit   = 1'b1;
                    bus.redirect_addr = bus.mepc_in & ~XLEN'(1);
                end else begin
                    bus.redirect_addr = trap_target;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.flush_req = (state_q == S_FLUSH);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_EXC;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed and random batches of requests, expectations queued by a
// reference model at issue time and popped by a negedge monitor whenever the DUT emits an event.
module tb_trap_sequencer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    bit   exp_busy = 1'b0;
    bit   exp_flush = 1'b0;

    logic [33:0]  exp_ack_q[$];  // {cycle, mret_ack, exception_ack}
    logic [127:0] exp_csr_q[$];  // {cycle, mcause, mepc, mtval}
    logic [64:0]  exp_rd_q[$];   // {cycle, mret_commit, redirect_addr}

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_sequencer_if #(.XLEN(XLEN)) bus ();
    trap_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic spurious(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] c;
            c = cyc;
            check("busy", 128'(bus.busy), 128'(exp_busy));
            check("flush_req", 128'(bus.flush_req), 128'(exp_flush));
            if (bus.exception_ack || bus.mret_ack) begin
                if (exp_ack_q.size() == 0) spurious("ack");
                else check("ack", 128'({c, bus.mret_ack, bus.exception_ack}), 128'(exp_ack_q.pop_front()));
            end
            if (bus.csr_we) begin
                if (exp_csr_q.size() == 0) spurious("csr_we");
                else check("csr_write", {c, bus.mcause, bus.mepc, bus.mtval}, exp_csr_q.pop_front());
            end
            if (bus.redirect_valid) begin
                if (exp_rd_q.size() == 0) spurious("redirect");
                else check("redirect", 128'({c, bus.mret_commit, bus.redirect_addr}), 128'(exp_rd_q.pop_front()));
            end
            if (bus.mret_commit && !bus.redirect_valid) spurious("mret_commit_alone");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exception_valid = 1'b0;
        bus.exception_code  = '0;
        bus.exception_pc    = '0;
        bus.exception_tval  = '0;
        bus.mret_valid      = 1'b0;
        bus.mip             = '0;
        bus.mie             = '0;
        bus.mstatus_mie     = 1'b0;
        bus.interrupt_pc    = '0;
        bus.mtvec           = '0;
        bus.mepc_in         = '0;
        bus.drain_ack       = 1'b0;
    endtask

    // Reference arbitration: 0 none, 1 exception, 2 mret, 3 interrupt.
    function automatic int pick(output logic [4:0] code);
        int          prio[7] = '{11, 3, 7, 9, 1, 5, 13};
        logic [15:0] pend;
        pend = bus.mip & bus.mie;
        code = '0;
        if (bus.exception_valid) begin
            code = bus.exception_code;
            return 1;
        end
        if (bus.mret_valid) return 2;
        if (bus.mstatus_mie) begin
            foreach (prio[i]) begin
                if (pend[prio[i]]) begin
                    code = 5'(prio[i]);
                    return 3;
                end
            end
        end
        return 0;
    endfunction

    // Runs one accept cycle from IDLE; the drain comes d cycles after the first flush cycle.
    task automatic serve(input int d, input bit do_rst);
        int          k;
        logic [4:0]  code;
        logic [31:0] cause, epc, tval, target, c0, y;
        cause = '0; epc = '0; tval = '0;
        k = pick(code);
        bus.drain_ack = 1'($urandom_range(0, 1));
        if (k == 0) begin
            step();
            bus.drain_ack = 1'b0;
            return;
        end
        c0 = cyc;
        case (k)
            1: begin
                cause = {27'd0, code};
                epc   = bus.exception_pc & ~32'h1;
                tval  = bus.exception_tval;
                exp_ack_q.push_back({c0, 2'b01});
            end
            2: exp_ack_q.push_back({c0, 2'b10});
            default: cause = 32'h8000_0000 | {27'd0, code};
        endcase
        step();
        bus.drain_ack = 1'b0;
        exp_busy  = 1'b1;
        exp_flush = 1'b1;
        if (k == 1) bus.exception_valid = 1'b0;
        if (k == 2) bus.mret_valid = 1'b0;
        if (k == 3) bus.mip = '0;
        if (do_rst) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            exp_busy  = 1'b0;
            exp_flush = 1'b0;
            @(negedge clk);
            check("rst_mid_ctrl", 128'({bus.exception_ack, bus.mret_ack, bus.csr_we, bus.mret_commit,
                                         bus.redirect_valid, bus.flush_req, bus.busy}), 128'(0));
            check("rst_mid_data", {bus.mcause, bus.mepc, bus.mtval, bus.redirect_addr}, 128'(0));
            return;
        end
        repeat (d) step();
        bus.drain_ack    = 1'b1;
        bus.interrupt_pc = $urandom;
        if (k == 3) epc = bus.interrupt_pc;
        if (k == 2) begin
            target = bus.mepc_in & ~32'h1;
        end else begin
            target = bus.mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
            if (k == 3 && bus.mtvec[1:0] == 2'b01) target = target + 4 * code;
`endif
        end
        y = cyc;
        if (k != 2) begin
            exp_csr_q.push_back({y + 32'd1, cause, epc, tval});
            exp_rd_q.push_back({y + 32'd2, 1'b0, target});
        end else begin
            exp_rd_q.push_back({y + 32'd1, 1'b1, target});
        end
        step();
        bus.drain_ack = 1'b0;
        exp_flush = 1'b0;
        if (k != 2) step();
        step();
        exp_busy = 1'b0;
    endtask

    task automatic random_batch();
        bus.exception_valid = ($urandom_range(0, 2) == 0);
        bus.exception_code  = 5'($urandom_range(0, 15));
        bus.exception_pc    = $urandom;
        bus.exception_tval  = $urandom;
        bus.mret_valid      = ($urandom_range(0, 3) == 0);
        bus.mip             = 16'($urandom);
        bus.mie             = 16'($urandom);
        bus.mstatus_mie     = 1'($urandom_range(0, 1));
        bus.mtvec           = $urandom;
        bus.mepc_in         = $urandom;
        for (int n = 0; n < 3; n++) serve($urandom_range(0, 3), 1'b0);
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) step();
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_ctrl", 128'({bus.exception_ack, bus.mret_ack, bus.csr_we, bus.mret_commit,
                                   bus.redirect_valid, bus.flush_req, bus.busy}), 128'(0));
        check("reset_data", {bus.mcause, bus.mepc, bus.mtval, bus.redirect_addr}, 128'(0));
        step();
        rst = 1'b0;
        step();

        // Exception with a three-cycle drain delay.
        bus.mtvec = 32'h8000_0000;
        bus.exception_valid = 1'b1; bus.exception_code = 5'd2;
        bus.exception_pc = 32'h8000_0104; bus.exception_tval = 32'h0000_FFFF;
        serve(3, 1'b0);
        clear_inputs(); step();

        // Interrupt priority: MEI over MSI/MTI, then MSI over MTI.
        bus.mtvec = 32'h8000_0000; bus.mstatus_mie = 1'b1;
        bus.mip = 16'h0888; bus.mie = 16'h0888;
        serve(1, 1'b0);
        bus.mip = 16'h0888; bus.mie = 16'h0088;
        serve(0, 1'b0);
        clear_inputs(); step();

        // Simultaneous exception, mret and MTI.
        bus.mtvec = 32'h8000_0000; bus.mepc_in = 32'h8000_0040; bus.mstatus_mie = 1'b1;
        bus.exception_valid = 1'b1; bus.exception_code = 5'd11; bus.exception_pc = 32'h8000_0011;
        bus.exception_tval = 32'h1234_5678; bus.mret_valid = 1'b1;
        bus.mip = 16'h0080; bus.mie = 16'h0080;
        for (int n = 0; n < 3; n++) serve(n, 1'b0);
        clear_inputs(); step();

        // mret with an odd mepc.
        bus.mepc_in = 32'h8000_0201; bus.mret_valid = 1'b1;
        serve(0, 1'b0);
        clear_inputs(); step();

        // Vectored-mode mtvec: interrupt then exception.
        bus.mtvec = 32'h8000_0001; bus.mstatus_mie = 1'b1;
        bus.mip = 16'h0080; bus.mie = 16'h0080;
        serve(0, 1'b0);
        bus.exception_valid = 1'b1; bus.exception_code = 5'd3; bus.exception_pc = 32'h8000_0300;
        serve(2, 1'b0);
        clear_inputs(); step();

        // Reset while flushing an exception.
        bus.exception_valid = 1'b1; bus.exception_code = 5'd5; bus.exception_pc = 32'h8000_0500;
        serve(2, 1'b1);
        clear_inputs(); step();

        // Globally disabled interrupts never leave IDLE.
        bus.mstatus_mie = 1'b0; bus.mip = 16'h0888; bus.mie = 16'h0888;
        repeat (5) serve(0, 1'b0);
        clear_inputs(); step();

        for (int t = 0; t < 60; t++) random_batch();

        repeat (4) step();
        check("pending_expectations", 128'(exp_ack_q.size() + exp_csr_q.size() + exp_rd_q.size()), 128'(0));
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
